btn_event_arbiter: RTL

Turns N debounced switch/button levels into timestamp-free discrete events: press, long-press, auto-repeat and release. It sits directly behind the per-button switch debouncers. It serialises all buttons' events onto one valid/ready event port, using a round-robin arbiter so the downstream consumer (menu FSM, counter control) sees one event per handshake.

---
 rtl/btn_evt_pkg.sv | 24 ++
 rtl/btn_event_fsm.sv | 140 ++++++++++++++
 rtl/btn_event_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event arbiter.
//   evt_code_t  : event codes carried on the serialised event port
//   btn_state_t : per-button hold-tracking FSM state
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EvtPress   = 2'd0,
        EvtLong    = 2'd1,
        EvtRepeat  = 2'd2,
        EvtRelease = 2'd3
    } evt_code_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StHeld     = 2'd1,
        StLongHeld = 2'd2
    } btn_state_t;

    // Hold counter width: enough to reach the larger of the two intervals.
    function automatic int unsigned hold_cnt_width(int unsigned long_c, int unsigned rep_c);
        return $clog2(((long_c > rep_c) ? long_c : rep_c) + 1);
    endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// Per-button event generator: edge detect, hold counter, press/long/repeat/release FSM and
// a single-entry pending slot that the top-level arbiter drains.
//   clk, rst   : clock, asynchronous active-high reset
//   btn_i      : debounced button level
//   grant_i    : arbiter takes the pending slot on this edge
//   held_o     : registered button level
//   full_o     : pending slot holds an event
//   code_o     : pending event code
//   ovf_set_o  : an event collided with an ungranted full slot this cycle
module btn_event_fsm
    import btn_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_i,
    input  logic      grant_i,
    output logic      held_o,
    output logic      full_o,
    output evt_code_t code_o,
    output logic      ovf_set_o
);

    localparam int unsigned CntW = hold_cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

    btn_state_t      state_q;
    logic [CntW-1:0] cnt_q;
    logic            held_q;
    logic            full_q;
    evt_code_t       code_q;

    logic      rise, fall;
    logic      gen;
    evt_code_t gen_code;

    assign rise = btn_i & ~held_q;
    assign fall = ~btn_i & held_q;

    // Event produced this cycle; release wins over a coincident long/repeat.
    always_comb begin
        gen      = 1'b0;
        gen_code = EvtPress;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    gen      = 1'b1;
                    gen_code = EvtPress;
                end
            end
            StHeld: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_code = EvtRelease;
                end else if (cnt_q == LongLast) begin
                    gen      = 1'b1;
                    gen_code = EvtLong;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_code = EvtRelease;
                end else if (cnt_q == RepLast) begin
                    gen      = 1'b1;
                    gen_code = EvtRepeat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            full_q  <= 1'b0;
            code_q  <= EvtPress;
        end else begin
            held_q <= btn_i;

            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        cnt_q   <= '0;
                        state_q <= StHeld;
                    end
                end
                StHeld: begin
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (cnt_q == LongLast) begin
                        cnt_q   <= '0;
                        state_q <= StLongHeld;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StLongHeld: begin
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (cnt_q == RepLast) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase

            if (grant_i) begin
                full_q <= 1'b0;
            end
            if (gen) begin
                if (!full_q || grant_i) begin
                    full_q <= 1'b1;
                    code_q <= gen_code;
                end else if (gen_code == EvtRelease) begin
                    // Final state matters most: a release replaces the stale pending event.
                    code_q <= EvtRelease;
                end
            end
        end
    end

    assign ovf_set_o = gen & full_q & ~grant_i;
    assign held_o    = held_q;
    assign full_o    = full_q;
    assign code_o    = code_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// Serialises press/long/repeat/release events from N_BTN debounced buttons onto one
// valid/ready port through a round-robin arbiter with a registered output stage.
//   clk, rst   : clock, asynchronous active-high reset
//   btn_clean  : debounced button levels (1 = pressed)
//   evt_valid/evt_ready/evt_btn/evt_code : event handshake port
//   held       : registered copy of btn_clean
//   ovf        : sticky per-button dropped-event flags, cleared by ovf_clr
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           btn_clean,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(N_BTN)-1:0]   evt_btn,
    output logic [1:0]                 evt_code,
    output logic [N_BTN-1:0]           held,
    output logic [N_BTN-1:0]           ovf,
    input  logic                       ovf_clr
);

    localparam int unsigned IdxW = $clog2(N_BTN);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BTN - 1);

    logic [N_BTN-1:0] slot_full;
    evt_code_t        slot_code [N_BTN];
    logic [N_BTN-1:0] ovf_set;
    logic [N_BTN-1:0] grant;

    logic            evt_valid_q;
    logic [IdxW-1:0] evt_btn_q;
    evt_code_t       evt_code_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [N_BTN-1:0] ovf_q;

    logic            load;
    logic            found;
    logic [IdxW-1:0] gnt_idx;
    logic [IdxW-1:0] cand;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_event_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .btn_i     (btn_clean[gi]),
            .grant_i   (grant[gi]),
            .held_o    (held[gi]),
            .full_o    (slot_full[gi]),
            .code_o    (slot_code[gi]),
            .ovf_set_o (ovf_set[gi])
        );
    end

    // First full slot searching upward from rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            cand = IdxW'((32'(rr_ptr_q) + k) % N_BTN);
            if (!found && slot_full[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign load = ~evt_valid_q | evt_ready;

    always_comb begin
        grant = '0;
        if (load && found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_code_q  <= EvtPress;
            rr_ptr_q    <= '0;
            ovf_q       <= '0;
        end else begin
            if (load) begin
                evt_valid_q <= found;
                if (found) begin
                    evt_btn_q  <= gnt_idx;
                    evt_code_q <= slot_code[gnt_idx];
                    rr_ptr_q   <= (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxW'(1);
                end
            end
            // A new drop in the same cycle as a clear stays visible.
            ovf_q <= (ovf_clr ? '0 : ovf_q) | ovf_set;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_btn   = evt_btn_q;
    assign evt_code  = evt_code_q;
    assign ovf       = ovf_q;

endmodule
